// File: rtl/mtimer_if.sv
// Dmem-style responder port of the machine timer: select, read strobe, word address,
// byte write enables, write data and registered read data.
interface mtimer_if #(
  parameter int unsigned ADDR_W = 3
) ();
  logic              ena_i;
  logic              read_i;
  logic [ADDR_W-1:0] addr_i;
  logic [31:0]       rdata_o;
  logic [3:0]        wsel_byte_i;
  logic [31:0]       wdata_i;

  modport master (
    output ena_i,
    output read_i,
    output addr_i,
    output wsel_byte_i,
    output wdata_i,
    input  rdata_o
  );

  modport slave (
    input  ena_i,
    input  read_i,
    input  addr_i,
    input  wsel_byte_i,
    input  wdata_i,
    output rdata_o
  );
endinterface

// File: rtl/mtimer.sv
// Memory-mapped machine timer: free-running 64-bit mtime compared against mtimecmp.
// Optional tick prescaler enabled by defining MTIMER_PRESCALER_EN (ctrl at word 4).
module mtimer #(
  parameter int unsigned ADDR_W     = 3,
  parameter int unsigned PRESCALE_W = 16,
  parameter logic [63:0] CMP_RST    = 64'hFFFF_FFFF_FFFF_FFFF
) (
  input  logic       clk_i,
  input  logic       rst_i,
  mtimer_if.slave    bus,
  output logic       irq_timer_o
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned MAP_W  = 3;

  localparam logic [MAP_W-1:0] W_MTIME_LO = 3'd0;
  localparam logic [MAP_W-1:0] W_MTIME_HI = 3'd1;
  localparam logic [MAP_W-1:0] W_CMP_LO   = 3'd2;
  localparam logic [MAP_W-1:0] W_CMP_HI   = 3'd3;
  localparam logic [MAP_W-1:0] W_CTRL     = 3'd4;

  // Parameter sanity: the map needs 3 address bits, ctrl must fit in one word.
  if (ADDR_W < MAP_W) begin : g_bad_addr_w
    $error("mtimer: ADDR_W must be at least 3");
  end
  if ((PRESCALE_W == 0) || (PRESCALE_W > DATA_W)) begin : g_bad_prescale_w
    $error("mtimer: PRESCALE_W must be in 1..32");
  end

  logic [63:0]       mtime_q, mtime_d;
  logic [63:0]       cmp_q, cmp_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              irq_q, irq_d;

  logic [ADDR_W-1:0] addr;
  logic [MAP_W-1:0]  word;
  logic              rd_en;
  logic              wr_en;
  logic              tick;
  logic [DATA_W-1:0] rd_word;
  logic [DATA_W-1:0] ctrl_word;

  function automatic logic [DATA_W-1:0] merge_bytes(
    input logic [DATA_W-1:0] old_val,
    input logic [DATA_W-1:0] new_val,
    input logic [3:0]        sel
  );
    logic [DATA_W-1:0] res;
    res = old_val;
    for (int b = 0; b < 4; b++) begin
      if (sel[b]) res[b*8 +: 8] = new_val[b*8 +: 8];
    end
    return res;
  endfunction

  assign addr  = bus.addr_i;
  assign word  = addr[MAP_W-1:0];
  assign rd_en = bus.ena_i & bus.read_i;
  assign wr_en = bus.ena_i & (|bus.wsel_byte_i);

`ifdef MTIMER_PRESCALER_EN
  logic [PRESCALE_W-1:0] ctrl_q, ctrl_d;
  logic [PRESCALE_W-1:0] pcnt_q, pcnt_d;

  // Tick once every ctrl+1 cycles; a ctrl write restarts the count.
  always_comb begin
    ctrl_d = ctrl_q;
    pcnt_d = pcnt_q + PRESCALE_W'(1);
    tick   = (pcnt_q == ctrl_q);
    if (tick) pcnt_d = '0;
    if (wr_en && (word == W_CTRL)) begin
      ctrl_d = PRESCALE_W'(merge_bytes(DATA_W'(ctrl_q), bus.wdata_i, bus.wsel_byte_i));
      pcnt_d = '0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ctrl_q <= '0;
      pcnt_q <= '0;
    end else begin
      ctrl_q <= ctrl_d;
      pcnt_q <= pcnt_d;
    end
  end

  assign ctrl_word = DATA_W'(ctrl_q);
`else
  assign tick      = 1'b1;
  assign ctrl_word = '0;
`endif

  // mtime/mtimecmp update; any mtime write suppresses the increment for all 64 bits.
  always_comb begin
    mtime_d = mtime_q;
    cmp_d   = cmp_q;
    if (tick) mtime_d = mtime_q + 64'(1);
    if (wr_en) begin
      unique case (word)
        W_MTIME_LO: mtime_d = {mtime_q[63:32],
                               merge_bytes(mtime_q[31:0], bus.wdata_i, bus.wsel_byte_i)};
        W_MTIME_HI: mtime_d = {merge_bytes(mtime_q[63:32], bus.wdata_i, bus.wsel_byte_i),
                               mtime_q[31:0]};
        W_CMP_LO:   cmp_d   = {cmp_q[63:32],
                               merge_bytes(cmp_q[31:0], bus.wdata_i, bus.wsel_byte_i)};
        W_CMP_HI:   cmp_d   = {merge_bytes(cmp_q[63:32], bus.wdata_i, bus.wsel_byte_i),
                               cmp_q[31:0]};
        default:    ;
      endcase
    end
  end

  // Read mux over pre-edge register values; unmapped words read 0.
  always_comb begin
    rd_word = '0;
    unique case (word)
      W_MTIME_LO: rd_word = mtime_q[31:0];
      W_MTIME_HI: rd_word = mtime_q[63:32];
      W_CMP_LO:   rd_word = cmp_q[31:0];
      W_CMP_HI:   rd_word = cmp_q[63:32];
      W_CTRL:     rd_word = ctrl_word;
      default:    rd_word = '0;
    endcase
  end

  always_comb begin
    rdata_d = rdata_q;
    if (rd_en) rdata_d = rd_word;
    irq_d = (mtime_q >= cmp_q);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mtime_q <= '0;
      cmp_q   <= CMP_RST;
      rdata_q <= '0;
      irq_q   <= 1'b0;
    end else begin
      mtime_q <= mtime_d;
      cmp_q   <= cmp_d;
      rdata_q <= rdata_d;
      irq_q   <= irq_d;
    end
  end

  assign bus.rdata_o = rdata_q;
  assign irq_timer_o = irq_q;

endmodule

// File: tb/tb_mtimer.sv
// Directed self-checking bench for mtimer; inputs driven and outputs sampled on negedge.
module tb_mtimer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic irq;
  int   checks = 0;
  int   errors = 0;

  mtimer_if #(.ADDR_W(3)) bus ();

  mtimer #(.ADDR_W(3)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .bus         (bus.slave),
    .irq_timer_o (irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    bus.ena_i       = 1'b0;
    bus.read_i      = 1'b0;
    bus.addr_i      = '0;
    bus.wsel_byte_i = '0;
    bus.wdata_i     = '0;
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic wr(input logic [2:0] a, input logic [3:0] sel, input logic [31:0] d);
    bus.ena_i = 1'b1; bus.addr_i = a; bus.wsel_byte_i = sel; bus.wdata_i = d;
    cyc();
    idle();
  endtask

  task automatic rd(input logic [2:0] a);
    bus.ena_i = 1'b1; bus.read_i = 1'b1; bus.addr_i = a;
    cyc();
    idle();
  endtask

  initial begin
    idle();
    repeat (3) cyc();
    chk("reset_rdata", bus.rdata_o, 32'h0);
    chk("reset_irq", 32'(irq), 32'h0);
    rst = 1'b0;

    rd(3'd2); chk("cmp_lo_rst", bus.rdata_o, 32'hFFFF_FFFF);
    rd(3'd3); chk("cmp_hi_rst", bus.rdata_o, 32'hFFFF_FFFF);

    // Byte-enable write with same-cycle read of the same word.
    bus.ena_i = 1'b1; bus.read_i = 1'b1; bus.addr_i = 3'd2;
    bus.wsel_byte_i = 4'b0010; bus.wdata_i = 32'hAABB_CCDD;
    cyc(); idle();
    chk("rw_same_cycle_old", bus.rdata_o, 32'hFFFF_FFFF);
    rd(3'd2); chk("byte_write", bus.rdata_o, 32'hFFFF_CCFF);
    wr(3'd2, 4'hF, 32'hFFFF_FFFF);

    // Compare: mtime from 0, mtimecmp = 16.
    wr(3'd3, 4'hF, 32'h0);
    wr(3'd1, 4'hF, 32'h0);
    wr(3'd0, 4'hF, 32'h0);
    wr(3'd2, 4'hF, 32'h10);
    repeat (14) cyc();
    chk("irq_before_p15", 32'(irq), 32'h0);
    cyc(); chk("irq_at_mtime16", 32'(irq), 32'h0);
    cyc(); chk("irq_rise", 32'(irq), 32'h1);
    rd(3'd0); chk("mtime_17", bus.rdata_o, 32'd17);
    wr(3'd3, 4'hF, 32'h1);
    chk("irq_still_high", 32'(irq), 32'h1);
    cyc(); chk("irq_fall", 32'(irq), 32'h0);

    // Carry from lo into hi; write cycle shows no increment.
    wr(3'd1, 4'hF, 32'h0);
    wr(3'd0, 4'hF, 32'hFFFF_FFFE);
    rd(3'd0); chk("collision_no_inc", bus.rdata_o, 32'hFFFF_FFFE);
    rd(3'd0); chk("lo_ff", bus.rdata_o, 32'hFFFF_FFFF);
    rd(3'd0); chk("lo_carry", bus.rdata_o, 32'h0);
    rd(3'd1); chk("hi_carry", bus.rdata_o, 32'h1);

    // Full 64-bit wrap.
    wr(3'd1, 4'hF, 32'hFFFF_FFFF);
    wr(3'd0, 4'hF, 32'hFFFF_FFFF);
    rd(3'd1); chk("hi_all_ones", bus.rdata_o, 32'hFFFF_FFFF);
    chk("irq_high_max", 32'(irq), 32'h1);
    rd(3'd1); chk("hi_wrapped", bus.rdata_o, 32'h0);
    chk("irq_low_after_wrap", 32'(irq), 32'h0);

    // Unmapped word and disabled accesses.
    rd(3'd2); chk("cmp_lo_16", bus.rdata_o, 32'h10);
    wr(3'd6, 4'hF, 32'h1234);
    rd(3'd6); chk("unmapped_read", bus.rdata_o, 32'h0);
    bus.ena_i = 1'b0; bus.read_i = 1'b1; bus.addr_i = 3'd2;
    cyc(); idle();
    chk("read_ena_low_hold", bus.rdata_o, 32'h0);
    bus.ena_i = 1'b0; bus.addr_i = 3'd2; bus.wsel_byte_i = 4'hF; bus.wdata_i = 32'h5;
    cyc(); idle();
    rd(3'd2); chk("write_ena_low_ignored", bus.rdata_o, 32'h10);

    // Prescaler / ctrl word.
    wr(3'd4, 4'hF, 32'h3);
    rd(3'd4);
`ifdef MTIMER_PRESCALER_EN
    chk("ctrl_read", bus.rdata_o, 32'h3);
`else
    chk("ctrl_read", bus.rdata_o, 32'h0);
`endif
    wr(3'd1, 4'hF, 32'h0);
    wr(3'd0, 4'hF, 32'h0);
    repeat (40) cyc();
    rd(3'd0);
`ifdef MTIMER_PRESCALER_EN
    chk("mtime_40_cycles", bus.rdata_o, 32'd10);
`else
    chk("mtime_40_cycles", bus.rdata_o, 32'd40);
`endif

    // Async reset mid-count clears outputs without a clock edge.
    wr(3'd1, 4'hF, 32'hFFFF_FFFF);
    cyc();
    chk("irq_pre_reset", 32'(irq), 32'h1);
    rd(3'd3); chk("rdata_pre_reset", bus.rdata_o, 32'h1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_rdata", bus.rdata_o, 32'h0);
    chk("async_rst_irq", 32'(irq), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    rd(3'd2); chk("cmp_lo_after_rst", bus.rdata_o, 32'hFFFF_FFFF);
    rd(3'd3); chk("cmp_hi_after_rst", bus.rdata_o, 32'hFFFF_FFFF);
    rd(3'd0); chk("mtime_after_rst", bus.rdata_o, 32'd2);
    chk("irq_after_rst", 32'(irq), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
